pixel_stream_tx: RTL and testbench
==================================

PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 1920, active pixels per line (>=2).
REQ-002 SHALL have parameter HEIGHT, default 1080, lines per frame (>=1).
REQ-003 SHALL have parameter HBLANK, default 16, idle cycles after each non-final line (>=0).
REQ-004 SHALL have parameter VBLANK, default 300, idle cycles after final line (>=1; >=257 when driving the HE core).
REQ-005 SHALL have parameter ADDR_W, default 21, frame-RAM address width (2^ADDR_W >= WIDTH*HEIGHT).
REQ-006 SHALL have ports: clk input 1 clock; rst_n input 1 reset. Reset is rst_n, asynchronous, active-low; clock is clk.
REQ-007 SHALL have ports: start input 1 (one-cycle frame trigger); continuous input 1 (level, loop frames); abort input 1 (synchronous stop).
REQ-008 SHALL have ports: mem_rd_en output 1; mem_rd_addr output ADDR_W; mem_rd_data input 8 (valid exactly 1 cycle after mem_rd_en).
REQ-009 SHALL have ports: dst_valid output 1; dst_data output 8; dst_sof output 1; dst_eol output 1; dst_last output 1 (end of frame).
REQ-010 SHALL have ports: busy output 1; frame_done output 1 (one-cycle pulse).

Function
REQ-011 SHALL implement FSM states IDLE, ACTIVE, HBLANK, VBLANK.
REQ-012 SHALL, in IDLE with start=1, enter ACTIVE next cycle with x=0, y=0, mem_rd_addr=0.
REQ-013 SHALL, in ACTIVE, assert mem_rd_en every cycle, present the current linear address, and increment x and address by 1 per cycle.
REQ-014 SHALL, at x=WIDTH-1 in ACTIVE: y<HEIGHT-1 -> HBLANK (or ACTIVE directly if HBLANK=0) with x=0, y+1; y=HEIGHT-1 -> VBLANK.
REQ-015 SHALL hold mem_rd_en=0 for exactly HBLANK cycles in HBLANK and VBLANK cycles in VBLANK.
REQ-016 SHALL, at end of VBLANK: continuous=1 -> ACTIVE with x=y=0, address=0; else IDLE.
REQ-017 SHALL register dst_valid as mem_rd_en delayed 1 cycle; dst_data = mem_rd_data when dst_valid=1, else 8'h00.
REQ-018 SHALL register dst_sof/dst_eol/dst_last aligned with dst_valid: sof on pixel (0,0), eol on x=WIDTH-1, last on (WIDTH-1, HEIGHT-1); never asserted with dst_valid=0.
REQ-019 SHALL pulse frame_done one cycle, coincident with dst_last.
REQ-020 SHALL drive busy=1 whenever state != IDLE or dst_valid=1.
REQ-021 SHALL ignore start when state != IDLE.
REQ-022 SHALL sample continuous only at end of VBLANK; deassertion mid-frame completes the current frame.
REQ-023 SHALL, on abort=1 in any state, enter IDLE next cycle, clear counters/address to 0, and force dst_valid/sof/eol/last/frame_done to 0 from the next cycle (in-flight pixel discarded); abort has priority over start.
REQ-024 SHALL keep mem_rd_addr at 0 in IDLE and wrap it to 0 after WIDTH*HEIGHT-1.
REQ-025 SHALL, with start=1 and continuous=1 held constantly, emit back-to-back frames with period HEIGHT*WIDTH + (HEIGHT-1)*HBLANK + VBLANK cycles.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously set state=IDLE, x=y=0, mem_rd_addr=0, mem_rd_en=0, dst_valid=dst_sof=dst_eol=dst_last=frame_done=busy=0, dst_data=0.
REQ-027 SHALL, on reset asserted mid-frame, discard the frame; first output after release occurs only after a new start.

Verification (WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=3, RAM data = address)
REQ-028 SHALL verify single frame: start pulse at cycle 0, continuous=0 -> mem_rd_en cycles 1-4 and 7-10; dst_valid cycles 2-5 (data 0-3) and 8-11 (data 4-7); sof at 2; eol at 5 and 11; last and frame_done at 11; busy=0 from cycle 15.
REQ-029 SHALL verify continuous: continuous=1 -> second frame mem_rd_en restarts at cycle 14 with addr 0, period 13 cycles; deassert in frame 2 -> IDLE after frame 2 VBLANK.
REQ-030 SHALL verify HBLANK=0 variant: dst_valid continuous for 8 cycles, eol after data 3, data 4 in the next cycle.
REQ-031 SHALL verify abort at cycle 3 -> dst_valid=0 from cycle 4, state IDLE, mem_rd_addr=0; a new start produces sof on data 0.
REQ-032 SHALL verify start pulses during ACTIVE/VBLANK are ignored (output identical to REQ-028).
REQ-033 SHALL verify rst_n low at cycle 6 -> all outputs 0 immediately; no dst_valid after release until start.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: raster-scans a frame RAM into a pixel stream (start/continuous/abort control, mem_rd_* RAM read port, dst_* stream with sof/eol/last, busy/frame_done status)
module pixel_stream_tx #(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int HBLANK = 16,
  parameter int VBLANK = 300,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              dst_valid,
  output logic [7:0]        dst_data,
  output logic              dst_sof,
  output logic              dst_eol,
  output logic              dst_last,
  output logic              busy,
  output logic              frame_done
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int BMAX = HBLANK > VBLANK ? HBLANK : VBLANK;
  localparam int CW   = $clog2(BMAX + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_VBLANK} state_t;
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] cnt;
  logic active, x_end, y_end;
  assign active      = state == ST_ACTIVE;
  assign x_end       = x == XW'(WIDTH - 1);
  assign y_end       = y == YW'(HEIGHT - 1);
  assign mem_rd_en   = active;
  assign dst_data    = dst_valid ? mem_rd_data : 8'h00;
  assign frame_done  = dst_last;
  assign busy        = state != ST_IDLE || dst_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      mem_rd_addr <= '0;
      dst_valid   <= 1'b0;
      dst_sof     <= 1'b0;
      dst_eol     <= 1'b0;
      dst_last    <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      mem_rd_addr <= '0;
      dst_valid   <= 1'b0;
      dst_sof     <= 1'b0;
      dst_eol     <= 1'b0;
      dst_last    <= 1'b0;
    end else begin
      dst_valid <= active;
      dst_sof   <= active && x == '0 && y == '0;
      dst_eol   <= active && x_end;
      dst_last  <= active && x_end && y_end;
      case (state)
        ST_IDLE: if (start) state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (!x_end) begin
            x           <= x + 1'b1;
            mem_rd_addr <= mem_rd_addr + 1'b1;
          end else if (y_end) begin
            x           <= '0;
            y           <= '0;
            mem_rd_addr <= '0;
            cnt         <= CW'(VBLANK - 1);
            state       <= ST_VBLANK;
          end else begin
            x           <= '0;
            y           <= y + 1'b1;
            mem_rd_addr <= mem_rd_addr + 1'b1;
            cnt         <= CW'(HBLANK - 1);
            state       <= HBLANK == 0 ? ST_ACTIVE : ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? ST_ACTIVE : ST_HBLANK;
        end
        ST_VBLANK: begin
          cnt   <= cnt - 1'b1;
          state <= cnt != '0 ? ST_VBLANK : continuous ? ST_ACTIVE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: randomized and directed bench for pixel_stream_tx against a frame-schedule reference model
module tb_pixel_stream_tx;
  localparam int W = 4, H = 2, VB = 3, AW = 4;
  localparam int HBK [2] = '{2, 0};
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [7:0] ram [16];
  logic en [2], valid [2], sof [2], eol [2], last [2], done [2], busy [2];
  logic [AW-1:0] addr [2];
  logic [7:0] rdata [2], data [2];
  int checks = 0, errors = 0;
  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .VBLANK(VB), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .mem_rd_en(en[0]), .mem_rd_addr(addr[0]), .mem_rd_data(rdata[0]),
    .dst_valid(valid[0]), .dst_data(data[0]), .dst_sof(sof[0]), .dst_eol(eol[0]),
    .dst_last(last[0]), .busy(busy[0]), .frame_done(done[0]));
  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .VBLANK(VB), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .mem_rd_en(en[1]), .mem_rd_addr(addr[1]), .mem_rd_data(rdata[1]),
    .dst_valid(valid[1]), .dst_data(data[1]), .dst_sof(sof[1]), .dst_eol(eol[1]),
    .dst_last(last[1]), .busy(busy[1]), .frame_done(done[1]));
  always #5 clk = ~clk;
  always @(posedge clk) for (int k = 0; k < 2; k++) rdata[k] <= ram[addr[k]];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int period(input int hb);
    return H * W + (H - 1) * hb + VB;
  endfunction
  function automatic bit rd(input int t, input int hb);
    return t / (W + hb) < H && t % (W + hb) < W;
  endfunction
  function automatic int lin(input int t, input int hb);
    return (t / (W + hb)) * W + t % (W + hb);
  endfunction
  bit m_run [2], p_v [2], p_s [2], p_e [2], p_l [2];
  int m_t [2], p_a [2];
  always @(posedge clk or negedge rst_n) begin
    bit e;
    int a;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || abort) begin
        m_run[k] <= 0; m_t[k] <= 0;
        p_v[k] <= 0; p_s[k] <= 0; p_e[k] <= 0; p_l[k] <= 0; p_a[k] <= 0;
      end else begin
        e = m_run[k] && rd(m_t[k], HBK[k]);
        a = lin(m_t[k], HBK[k]);
        p_v[k] <= e;
        p_a[k] <= a;
        p_s[k] <= e && a == 0;
        p_e[k] <= e && a % W == W - 1;
        p_l[k] <= e && a == W * H - 1;
        if (!m_run[k]) begin
          m_run[k] <= start;
          m_t[k] <= 0;
        end else if (m_t[k] == period(HBK[k]) - 1) begin
          m_run[k] <= continuous;
          m_t[k] <= 0;
        end else m_t[k] <= m_t[k] + 1;
      end
    end
  end
  always @(posedge clk) begin
    bit e;
    #3;
    for (int k = 0; k < 2; k++) begin
      e = m_run[k] && rd(m_t[k], HBK[k]);
      check($sformatf("d%0d.mem_rd_en", k), en[k], e);
      if (e || !m_run[k]) check($sformatf("d%0d.mem_rd_addr", k), addr[k], e ? lin(m_t[k], HBK[k]) : 0);
      check($sformatf("d%0d.dst_valid", k), valid[k], p_v[k]);
      check($sformatf("d%0d.dst_data", k), data[k], p_v[k] ? ram[p_a[k]] : 8'h00);
      check($sformatf("d%0d.dst_sof", k), sof[k], p_s[k]);
      check($sformatf("d%0d.dst_eol", k), eol[k], p_e[k]);
      check($sformatf("d%0d.dst_last", k), last[k], p_l[k]);
      check($sformatf("d%0d.frame_done", k), done[k], p_l[k]);
      check($sformatf("d%0d.busy", k), busy[k], m_run[k] || p_v[k]);
    end
  end
  task automatic run_frame(input bit noise);
    int sof_at = -1, last_at = -1, done_at = -1, en_cnt = 0, late_busy = 0;
    logic [7:0] sof_data = 8'hxx;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #3;
      start = noise && (i == 3 || i == 12);
      if (sof[0] && sof_at < 0) begin sof_at = i; sof_data = data[0]; end
      if (last[0]) last_at = i;
      if (done[0]) done_at = i;
      if (en[0]) en_cnt++;
      if (i >= 15 && busy[0]) late_busy++;
    end
    check("frame.sof_cycle", sof_at, 2);
    check("frame.sof_data", sof_data, ram[0]);
    check("frame.last_cycle", last_at, 11);
    check("frame.done_cycle", done_at, 11);
    check("frame.rd_count", en_cnt, 8);
    check("frame.busy_after_14", late_busy, 0);
  endtask
  initial begin
    int idle_valid;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    #2;
    check("reset.busy", busy[0], 0);
    check("reset.valid", valid[0], 0);
    check("reset.addr", addr[0], 0);
    #21 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(0);
    run_frame(1);
    @(negedge clk);
    continuous = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #3;
      start = 1'b0;
      if (i == 13) check("cont.gap_en", en[0], 0);
      if (i == 14) begin
        check("cont.restart_en", en[0], 1);
        check("cont.restart_addr", addr[0], 0);
      end
      if (i == 20) continuous = 1'b0;
      if (i == 26) check("cont.vblank_busy", busy[0], 1);
      if (i == 27) check("cont.idle_en", en[0], 0);
      if (i == 28) check("cont.idle_busy", busy[0], 0);
    end
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #3;
      start = 1'b0;
      abort = i == 3;
      if (i == 4) begin
        check("abort.valid", valid[0], 0);
        check("abort.en", en[0], 0);
        check("abort.addr", addr[0], 0);
        check("abort.busy", busy[0], 0);
      end
    end
    run_frame(0);
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #3;
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d.en", k), en[k], 0);
      check($sformatf("rst%0d.valid", k), valid[k], 0);
      check($sformatf("rst%0d.busy", k), busy[k], 0);
      check($sformatf("rst%0d.data", k), data[k], 0);
      check($sformatf("rst%0d.addr", k), addr[k], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_valid = 0;
    repeat (20) begin
      @(posedge clk);
      #3;
      if (valid[0] || valid[1]) idle_valid++;
    end
    check("rst.no_output_until_start", idle_valid, 0);
    run_frame(0);
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    repeat (800) begin
      @(negedge clk);
      start = $urandom_range(7) == 0;
      abort = $urandom_range(59) == 0;
      if ($urandom_range(29) == 0) continuous = ~continuous;
    end
    @(negedge clk);
    start = 1'b0;
    continuous = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
